nice_xfer_seq: RTL and testbench

- Transfer sequencer directly upstream of the NICE memory interface stage.
- Takes one transfer command from the accelerator controller: LHS load, RHS load, per-channel parameter load, or DST store.
- Drives the memory interface's `state`, `bias_addr`, `buf_wr`, `buf_wr_sel` and the word handshakes, one outstanding word at a time.
- Returns load words with their index to the compute buffers, and fetches store words from the output buffer.

---
 rtl/nn_xfer_pkg.sv | 34 +++
 rtl/xfer_addr_gen.sv | 41 ++++
 rtl/nice_xfer_seq.sv | 144 ++++++++++++++
 tb/tb_nice_xfer_seq.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_xfer_pkg.sv
// nn_xfer_pkg: shared encodings for the NICE transfer sequencer.
//   OP_*   : command opcodes, also the value driven on the memory interface state bus
//   SEL_*  : per-channel parameter selects for parameter loads
//   xfer_state_t : sequencer FSM states
//   cmd_legal    : filters commands that must be ignored at start
package nn_xfer_pkg;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_LHS  = 2'b01;
    localparam logic [1:0] OP_RHS  = 2'b10;
    localparam logic [1:0] OP_DST  = 2'b11;

    localparam logic [1:0] SEL_SHIFT = 2'b00;
    localparam logic [1:0] SEL_MULT  = 2'b01;
    localparam logic [1:0] SEL_LBIAS = 2'b10;

    localparam int DEF_PARAM_SHIFT = 9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FIN
    } xfer_state_t;

    // The param select only matters for a parameter load, so an unused
    // select code on any other op does not reject the command.
    function automatic logic cmd_legal(input logic [1:0] op, input logic param,
                                       input logic [1:0] sel);
        return (op != OP_NONE) &&
               !(op == OP_RHS && param && !(sel inside {SEL_SHIFT, SEL_MULT, SEL_LBIAS}));
    endfunction

endpackage

// File: rtl/xfer_addr_gen.sv
// xfer_addr_gen: word counter and address former for the transfer sequencer.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_clr          : restart the word counter at zero (command accepted)
//   i_inc          : advance to the next word
//   i_param        : parameter load (index shifted into the param offset field)
//   i_len          : number of words in the command
//   o_k            : current word index
//   o_last         : the word at o_k is the final one of the command
//   o_addr         : byte offset (k*4) or parameter offset (k<<PARAM_SHIFT)
module xfer_addr_gen #(
    parameter int LEN_W       = 10,
    parameter int PARAM_SHIFT = 9
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic             i_param,
    input  logic [LEN_W-1:0] i_len,
    output logic [LEN_W-1:0] o_k,
    output logic             o_last,
    output logic [31:0]      o_addr
);

    logic [LEN_W-1:0] r_k;
    logic [LEN_W:0]   w_k_nxt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr)
            r_k <= '0;
        else if (i_inc)
            r_k <= r_k + LEN_W'(1);
    end

    // One extra bit so a full-length command cannot wrap before the compare.
    assign w_k_nxt = {1'b0, r_k} + (LEN_W+1)'(1);
    assign o_last  = w_k_nxt == {1'b0, i_len};
    assign o_k     = r_k;
    assign o_addr  = i_param ? (32'(r_k) << PARAM_SHIFT) : (32'(r_k) << 2);

endmodule

// File: rtl/nice_xfer_seq.sv
// nice_xfer_seq: one-word-at-a-time transfer sequencer in front of the NICE memory interface.
//   nice_clk, nice_rst_n       : clock, synchronous active-low reset
//   start/op/param/param_sel/len : transfer command, taken only while idle
//   busy, done, err            : command status (done is a one-cycle pulse, err is sticky)
//   state, bias_addr, buf_wr, buf_wr_sel : mode and offset to the memory interface
//   data_in_acq / data_out_rdy : load / store word request
//   nice_icb_*, data_in_rdy, data_out_acq, rd_data : bus handshake and load data
//   ld_valid, ld_data, ld_idx  : load word returned to the compute buffers
//   st_data, st_pop, wr_data   : store word fetched from the output buffer
module nice_xfer_seq
    import nn_xfer_pkg::*;
#(
    parameter int LEN_W       = 10,
    parameter int PARAM_SHIFT = DEF_PARAM_SHIFT
) (
    input  logic             nice_clk,
    input  logic             nice_rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             param,
    input  logic [1:0]       param_sel,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       state,
    output logic [31:0]      bias_addr,
    output logic             buf_wr,
    output logic [1:0]       buf_wr_sel,
    output logic             data_in_acq,
    output logic             data_out_rdy,
    input  logic             nice_icb_cmd_ready,
    input  logic             nice_icb_rsp_valid,
    input  logic             nice_icb_rsp_err,
    input  logic             data_in_rdy,
    input  logic             data_out_acq,
    input  logic [31:0]      rd_data,
    output logic             ld_valid,
    output logic [31:0]      ld_data,
    output logic [LEN_W-1:0] ld_idx,
    input  logic [31:0]      st_data,
    output logic             st_pop,
    output logic [31:0]      wr_data
);

    xfer_state_t      r_fsm, w_next;
    logic [1:0]       r_op, r_sel;
    logic             r_param, r_err, r_ld_valid;
    logic [LEN_W-1:0] r_len, r_ld_idx;
    logic [31:0]      r_ld_data, r_wr_data;
    logic             w_accept, w_store, w_rsp_err, w_ld_hit, w_st_hit, w_inc, w_last, w_pop;
    logic [LEN_W-1:0] w_k;
    logic [31:0]      w_addr;

    assign w_accept  = (r_fsm == S_IDLE) && start && cmd_legal(op, param, param_sel);
    assign w_store   = r_op == OP_DST;
    // A bus error wins over any data strobe in the same cycle; the word is dropped.
    assign w_rsp_err = (r_fsm == S_WAIT) && nice_icb_rsp_valid && nice_icb_rsp_err;
    assign w_ld_hit  = (r_fsm == S_WAIT) && !w_store && data_in_rdy && !w_rsp_err;
    assign w_st_hit  = (r_fsm == S_WAIT) && w_store && data_out_acq && !w_rsp_err;
    assign w_inc     = w_ld_hit || w_st_hit;

    xfer_addr_gen #(
        .LEN_W       (LEN_W),
        .PARAM_SHIFT (PARAM_SHIFT)
    ) u_addr (
        .i_clk   (nice_clk),
        .i_rst_n (nice_rst_n),
        .i_clr   (w_accept),
        .i_inc   (w_inc),
        .i_param (r_param),
        .i_len   (r_len),
        .o_k     (w_k),
        .o_last  (w_last),
        .o_addr  (w_addr)
    );

    always_ff @(posedge nice_clk) begin
        if (!nice_rst_n)
            r_fsm <= S_IDLE;
        else
            r_fsm <= w_next;
    end

    always_comb begin
        w_next = r_fsm;
        case (r_fsm)
            S_IDLE:  w_next = w_accept ? ((len == '0) ? S_FIN : S_ISSUE) : S_IDLE;
            S_ISSUE: w_next = nice_icb_cmd_ready ? S_WAIT : S_ISSUE;
            S_WAIT:  w_next = w_rsp_err ? S_FIN : (w_inc ? (w_last ? S_FIN : S_ISSUE) : S_WAIT);
            default: w_next = S_IDLE;
        endcase
        // The output buffer is popped on the transition into ISSUE so wr_data
        // already holds the word during the first ISSUE cycle. While idle the
        // op is not latched yet, so the incoming op decides.
        w_pop = nice_rst_n && (w_next == S_ISSUE) && (r_fsm != S_ISSUE) &&
                ((r_fsm == S_IDLE) ? (op == OP_DST) : w_store);
    end

    always_ff @(posedge nice_clk) begin
        if (!nice_rst_n) begin
            r_op       <= OP_NONE;
            r_param    <= 1'b0;
            r_sel      <= 2'b00;
            r_len      <= '0;
            r_err      <= 1'b0;
            r_ld_valid <= 1'b0;
            r_ld_data  <= '0;
            r_ld_idx   <= '0;
            r_wr_data  <= '0;
        end else begin
            r_ld_valid <= w_ld_hit;
            if (w_ld_hit) begin
                r_ld_data <= rd_data;
                r_ld_idx  <= w_k;
            end
            if (w_pop)
                r_wr_data <= st_data;
            if (w_accept) begin
                r_op    <= op;
                r_param <= param && (op == OP_RHS);
                r_sel   <= param_sel;
                r_len   <= len;
            end
            r_err <= w_accept ? 1'b0 : (r_err || w_rsp_err);
        end
    end

    assign busy         = r_fsm != S_IDLE;
    assign done         = r_fsm == S_FIN;
    assign err          = r_err;
    assign state        = busy ? r_op : OP_NONE;
    assign bias_addr    = busy ? w_addr : '0;
    assign buf_wr       = busy && r_param;
    assign buf_wr_sel   = busy ? r_sel : 2'b00;
    assign data_in_acq  = (r_fsm == S_ISSUE) && !w_store;
    assign data_out_rdy = (r_fsm == S_ISSUE) && w_store;
    assign ld_valid     = r_ld_valid;
    assign ld_data      = r_ld_data;
    assign ld_idx       = r_ld_idx;
    assign st_pop       = w_pop;
    assign wr_data      = r_wr_data;

endmodule

// File: tb/tb_nice_xfer_seq.sv
// tb_nice_xfer_seq: scoreboard bench for nice_xfer_seq with a reactive bus and output-buffer model.
module tb_nice_xfer_seq;
    import nn_xfer_pkg::*;

    localparam int LEN_W = 10;

    logic             nice_clk = 1'b0;
    logic             nice_rst_n = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       op = 2'b00;
    logic             param = 1'b0;
    logic [1:0]       param_sel = 2'b00;
    logic [LEN_W-1:0] len = '0;
    logic             busy, done, err, buf_wr, data_in_acq, data_out_rdy, ld_valid, st_pop;
    logic [1:0]       state, buf_wr_sel;
    logic [31:0]      bias_addr, ld_data, wr_data, st_data;
    logic [LEN_W-1:0] ld_idx;
    logic             nice_icb_cmd_ready = 1'b0;
    logic             nice_icb_rsp_valid = 1'b0;
    logic             nice_icb_rsp_err = 1'b0;
    logic             data_in_rdy = 1'b0;
    logic             data_out_acq = 1'b0;
    logic [31:0]      rd_data = '0;

    nice_xfer_seq #(.LEN_W(LEN_W), .PARAM_SHIFT(9)) dut (
        .nice_clk(nice_clk), .nice_rst_n(nice_rst_n), .start(start), .op(op), .param(param),
        .param_sel(param_sel), .len(len), .busy(busy), .done(done), .err(err), .state(state),
        .bias_addr(bias_addr), .buf_wr(buf_wr), .buf_wr_sel(buf_wr_sel),
        .data_in_acq(data_in_acq), .data_out_rdy(data_out_rdy),
        .nice_icb_cmd_ready(nice_icb_cmd_ready), .nice_icb_rsp_valid(nice_icb_rsp_valid),
        .nice_icb_rsp_err(nice_icb_rsp_err), .data_in_rdy(data_in_rdy),
        .data_out_acq(data_out_acq), .rd_data(rd_data), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_idx(ld_idx), .st_data(st_data), .st_pop(st_pop),
        .wr_data(wr_data)
    );

    always #5 nice_clk = ~nice_clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard queues: kind = {data_in_acq, data_out_rdy}, mode = {state, buf_wr, buf_wr_sel}.
    typedef struct {
        logic [31:0] addr;
        logic [1:0]  kind;
        logic [4:0]  mode;
        logic [31:0] wd;
    } req_t;
    typedef struct {
        logic [31:0] idx;
        logic [31:0] data;
    } ld_t;
    typedef struct {
        logic       err;
        logic [1:0] st;
    } done_t;

    req_t  q_req[$];
    ld_t   q_ld[$];
    done_t q_done[$];

    task automatic exp_req(input logic [31:0] a, input logic [1:0] k, input logic [4:0] m,
                           input logic [31:0] w);
        req_t r;
        r.addr = a; r.kind = k; r.mode = m; r.wd = w;
        q_req.push_back(r);
    endtask

    task automatic exp_ld(input logic [31:0] i, input logic [31:0] d);
        ld_t l;
        l.idx = i; l.data = d;
        q_ld.push_back(l);
    endtask

    task automatic exp_done(input logic e, input logic [1:0] s);
        done_t x;
        x.err = e; x.st = s;
        q_done.push_back(x);
    endtask

    // Bus and buffer behaviour, set by the stimulus only.
    int          cfg_delay = 0;
    int          cfg_lat = 0;
    int          cfg_err_idx = -1;
    logic        cfg_param = 1'b0;
    logic [31:0] cfg_base = '0;

    logic [31:0] st_mem [4] = '{32'hCAFE_0000, 32'hBEEF_0001, 32'h1111_2222, 32'h3333_4444};
    int          st_rd = 0;
    assign st_data = st_mem[st_rd[1:0]];
    always @(posedge nice_clk) if (st_pop) st_rd <= st_rd + 1;

    // Bus responder: grants cmd_ready after cfg_delay request cycles, answers
    // cfg_lat cycles after the accepting edge; word index recovered from the offset.
    initial begin
        int wcnt = 0;
        int lcnt = 0;
        int idx = 0;
        bit pend = 0;
        bit is_st = 0;
        forever begin
            @(posedge nice_clk);
            #1;
            nice_icb_cmd_ready = 1'b0;
            nice_icb_rsp_valid = 1'b0;
            nice_icb_rsp_err = 1'b0;
            data_in_rdy = 1'b0;
            data_out_acq = 1'b0;
            if (pend) begin
                if (lcnt == cfg_lat) begin
                    pend = 0;
                    lcnt = 0;
                    nice_icb_rsp_valid = 1'b1;
                    if (idx == cfg_err_idx) nice_icb_rsp_err = 1'b1;
                    else if (is_st) data_out_acq = 1'b1;
                    else begin
                        data_in_rdy = 1'b1;
                        rd_data = cfg_base + 32'(idx);
                    end
                end else lcnt++;
            end else if (data_in_acq || data_out_rdy) begin
                if (wcnt == cfg_delay) begin
                    nice_icb_cmd_ready = 1'b1;
                    pend = 1;
                    wcnt = 0;
                    is_st = data_out_rdy;
                    idx = int'(cfg_param ? (bias_addr >> 9) : (bias_addr >> 2));
                end else wcnt++;
            end
        end
    end

    // Monitor: compares every presented request, load word and completion.
    int    n_pop = 0;
    req_t  m_r;
    ld_t   m_l;
    done_t m_d;
    always @(negedge nice_clk) begin
        if (st_pop) n_pop++;
        if (data_in_acq || data_out_rdy) begin
            if (q_req.size() == 0) chk("req_unexpected", 32'({data_in_acq, data_out_rdy}), 0);
            else begin
                m_r = q_req[0];
                chk(nice_icb_cmd_ready ? "req_addr" : "hold_addr", bias_addr, m_r.addr);
                if (m_r.kind == 2'b01)
                    chk(nice_icb_cmd_ready ? "req_wdata" : "hold_wdata", wr_data, m_r.wd);
                if (nice_icb_cmd_ready) begin
                    chk("req_kind", 32'({data_in_acq, data_out_rdy}), 32'(m_r.kind));
                    chk("req_mode", 32'({state, buf_wr, buf_wr_sel}), 32'(m_r.mode));
                    void'(q_req.pop_front());
                end
            end
        end
        if (ld_valid) begin
            if (q_ld.size() == 0) chk("ld_unexpected", 32'(ld_valid), 0);
            else begin
                m_l = q_ld.pop_front();
                chk("ld_idx", 32'(ld_idx), m_l.idx);
                chk("ld_data", ld_data, m_l.data);
            end
        end
        if (done) begin
            if (q_done.size() == 0) chk("done_unexpected", 32'(done), 0);
            else begin
                m_d = q_done.pop_front();
                chk("done_err", 32'(err), 32'(m_d.err));
                chk("done_state", 32'(state), 32'(m_d.st));
                chk("done_busy", 32'(busy), 1);
            end
        end
    end

    task automatic drive_start(input logic [1:0] o, input logic p, input logic [1:0] s,
                               input logic [LEN_W-1:0] l);
        @(posedge nice_clk);
        #1;
        start = 1'b1; op = o; param = p; param_sel = s; len = l;
        @(posedge nice_clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge nice_clk);
            if (!busy) break;
        end
        chk({name, "_idle"}, 32'(busy), 0);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_ctl"}, 32'({busy, done, err, state, buf_wr, buf_wr_sel, data_in_acq,
                                 data_out_rdy, ld_valid, st_pop, ld_idx}), 0);
        chk({name, "_addr"}, bias_addr, 0);
        chk({name, "_ld_data"}, ld_data, 0);
        chk({name, "_wr_data"}, wr_data, 0);
    endtask

    initial begin
        int pops;
        int i;
        repeat (3) @(posedge nice_clk);
        #1 nice_rst_n = 1'b1;
        @(negedge nice_clk);
        chk_zero("reset");

        // LHS load, 3 words, immediate grant and response.
        cfg_base = 32'hA0; cfg_param = 1'b0; cfg_delay = 0; cfg_lat = 0;
        for (int k = 0; k < 3; k++) begin
            exp_req(32'(4 * k), 2'b10, {OP_LHS, 1'b0, 2'b00}, '0);
            exp_ld(32'(k), 32'hA0 + 32'(k));
        end
        exp_done(1'b0, OP_LHS);
        drive_start(OP_LHS, 1'b0, 2'b00, 3);
        wait_idle("lhs");
        chk("lhs_state_after", 32'(state), 0);

        // Parameter load, multiplier select, 2 words.
        cfg_base = 32'hB0; cfg_param = 1'b1;
        exp_req(32'h000, 2'b10, {OP_RHS, 1'b1, SEL_MULT}, '0);
        exp_req(32'h200, 2'b10, {OP_RHS, 1'b1, SEL_MULT}, '0);
        exp_ld(0, 32'hB0);
        exp_ld(1, 32'hB1);
        exp_done(1'b0, OP_RHS);
        drive_start(OP_RHS, 1'b1, SEL_MULT, 2);
        wait_idle("param");
        chk("param_bufwr_after", 32'({buf_wr, buf_wr_sel}), 0);

        // Store, 2 words, cmd_ready held off 3 cycles per word.
        cfg_param = 1'b0; cfg_delay = 3;
        pops = n_pop;
        exp_req(32'h0, 2'b01, {OP_DST, 1'b0, 2'b00}, 32'hCAFE_0000);
        exp_req(32'h4, 2'b01, {OP_DST, 1'b0, 2'b00}, 32'hBEEF_0001);
        exp_done(1'b0, OP_DST);
        drive_start(OP_DST, 1'b0, 2'b00, 2);
        wait_idle("store");
        chk("store_pops", 32'(n_pop - pops), 2);

        // RHS load aborted by a bus error on word 1.
        cfg_delay = 0; cfg_base = 32'hC0; cfg_err_idx = 1;
        exp_req(32'h0, 2'b10, {OP_RHS, 1'b0, 2'b00}, '0);
        exp_req(32'h4, 2'b10, {OP_RHS, 1'b0, 2'b00}, '0);
        exp_ld(0, 32'hC0);
        exp_done(1'b1, OP_RHS);
        drive_start(OP_RHS, 1'b0, 2'b00, 4);
        wait_idle("rsperr");
        repeat (3) @(negedge nice_clk);
        chk("err_sticky", 32'(err), 1);
        cfg_err_idx = -1;

        // Zero-length command: completion only, and it clears err.
        exp_done(1'b0, OP_LHS);
        drive_start(OP_LHS, 1'b0, 2'b00, 0);
        wait_idle("len0");
        chk("err_cleared", 32'(err), 0);

        // Illegal op and illegal param select are ignored.
        drive_start(OP_NONE, 1'b0, 2'b00, 2);
        @(negedge nice_clk);
        chk("illegal_op_busy", 32'(busy), 0);
        drive_start(OP_RHS, 1'b1, 2'b11, 2);
        @(negedge nice_clk);
        chk("illegal_sel_busy", 32'(busy), 0);

        // A second start while busy is ignored.
        cfg_base = 32'hD0;
        pops = n_pop;
        exp_req(32'h0, 2'b10, {OP_LHS, 1'b0, 2'b00}, '0);
        exp_ld(0, 32'hD0);
        exp_done(1'b0, OP_LHS);
        drive_start(OP_LHS, 1'b0, 2'b00, 1);
        drive_start(OP_DST, 1'b0, 2'b00, 2);
        wait_idle("busy_start");
        repeat (4) @(negedge nice_clk);
        chk("busy_start_ignored", 32'(busy), 0);
        chk("busy_start_no_pop", 32'(n_pop - pops), 0);

        // Reset while waiting for the first response of a 5-word load.
        cfg_base = 32'hE0; cfg_lat = 3;
        exp_req(32'h0, 2'b10, {OP_LHS, 1'b0, 2'b00}, '0);
        drive_start(OP_LHS, 1'b0, 2'b00, 5);
        for (i = 0; i < 50; i++) begin
            @(negedge nice_clk);
            if (data_in_acq && nice_icb_cmd_ready) break;
        end
        chk("rst_accept_seen", 32'(i < 50), 1);
        @(posedge nice_clk);
        #1 nice_rst_n = 1'b0;
        @(posedge nice_clk);
        #1 nice_rst_n = 1'b1;
        @(negedge nice_clk);
        chk_zero("rst_mid");
        chk("rst_mid_state", 32'(state), 0);
        repeat (8) @(negedge nice_clk);
        chk("rst_stays_idle", 32'(busy), 0);
        cfg_lat = 0;

        chk("queues_empty", 32'(q_req.size() + q_ld.size() + q_done.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
